ceespu_hazard_unit: RTL and testbench

// - Parametrised hazard/forwarding controller for the ceespu pipeline; replaces the fixed 2-source inline forward/stall logic in the top level.
// - Generates registered bypass selects for operands A/B over FWD_STAGES sources.
// - Detects load-use and long-latency (scoreboarded) hazards, raises stall/bubble, and sequences completion of multi-cycle ops onto the single writeback port.
// - Sits between decode and execute; the top level muxes operands with O_fwdA/O_fwdB.

---
 rtl/ceespu_hazard_if.sv | 55 +++++
 rtl/ceespu_hazard_unit.sv | 173 +++++++++++++++++
 tb/tb_ceespu_hazard_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ceespu_hazard_if.sv
// Decode/bypass/writeback signal bundle between the ceespu pipeline and its hazard unit.
// Statistics outputs exist only when CEESPU_HAZARD_STATS_EN is defined.
interface ceespu_hazard_if #(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 2,
    parameter int LAT_W      = 4
);
    localparam int FW = $clog2(FWD_STAGES + 1);

    logic                         I_stall_ext;
    logic                         I_flush;
    logic                         I_dec_valid;
    logic [REG_AW-1:0]            I_dec_regA;
    logic [REG_AW-1:0]            I_dec_regB;
    logic                         I_dec_useA;
    logic                         I_dec_useB;
    logic                         I_dec_we;
    logic [REG_AW-1:0]            I_dec_regD;
    logic                         I_dec_isLoad;
    logic                         I_dec_isLong;
    logic [LAT_W-1:0]             I_dec_lat;
    logic [FWD_STAGES-1:0]        I_fwd_we;
    logic [FWD_STAGES*REG_AW-1:0] I_fwd_regD;
    logic [FW-1:0]                O_fwdA;
    logic [FW-1:0]                O_fwdB;
    logic                         O_stall;
    logic                         O_bubble;
    logic                         O_sb_full;
    logic                         O_long_done;
    logic [REG_AW-1:0]            O_long_regD;
`ifdef CEESPU_HAZARD_STATS_EN
    logic [31:0]                  O_stat_stalls;
    logic [31:0]                  O_stat_long;
`endif

    modport slave (
        input  I_stall_ext, I_flush, I_dec_valid, I_dec_regA, I_dec_regB,
               I_dec_useA, I_dec_useB, I_dec_we, I_dec_regD, I_dec_isLoad,
               I_dec_isLong, I_dec_lat, I_fwd_we, I_fwd_regD,
        output O_fwdA, O_fwdB, O_stall, O_bubble, O_sb_full, O_long_done, O_long_regD
`ifdef CEESPU_HAZARD_STATS_EN
        , output O_stat_stalls, O_stat_long
`endif
    );

    modport master (
        output I_stall_ext, I_flush, I_dec_valid, I_dec_regA, I_dec_regB,
               I_dec_useA, I_dec_useB, I_dec_we, I_dec_regD, I_dec_isLoad,
               I_dec_isLong, I_dec_lat, I_fwd_we, I_fwd_regD,
        input  O_fwdA, O_fwdB, O_stall, O_bubble, O_sb_full, O_long_done, O_long_regD
`ifdef CEESPU_HAZARD_STATS_EN
        , input O_stat_stalls, O_stat_long
`endif
    );
endinterface

// File: rtl/ceespu_hazard_unit.sv
// ceespu hazard unit: registered bypass selects, load-use and long-op scoreboard stalls,
// and one-per-cycle writeback sequencing of long ops. Optional counters: CEESPU_HAZARD_STATS_EN.
module ceespu_hazard_unit #(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 2,
    parameter int SB_DEPTH   = 4,
    parameter int LAT_W      = 4
) (
    input  logic           I_clk,
    input  logic           I_rst_n,
    ceespu_hazard_if.slave hz
);
    localparam int FW = $clog2(FWD_STAGES + 1);

    logic                srcA_live, srcB_live, dst_live;
    logic                lu_stall, sb_stall, stall, sb_full, issue, alloc_req;
    logic [FW-1:0]       selA, selB;
    logic [FW-1:0]       fwdA_q, fwdA_d, fwdB_q, fwdB_d;
    logic                load_pending_q, load_pending_d;
    logic [REG_AW-1:0]   load_regD_q, load_regD_d;
    logic [SB_DEPTH-1:0] sb_valid_q, sb_valid_d;
    logic [REG_AW-1:0]   sb_regD_q [SB_DEPTH];
    logic [REG_AW-1:0]   sb_regD_d [SB_DEPTH];
    logic [LAT_W-1:0]    sb_cnt_q  [SB_DEPTH];
    logic [LAT_W-1:0]    sb_cnt_d  [SB_DEPTH];
    logic [SB_DEPTH-1:0] sb_hit, sb_ready;
    logic                retire_found, alloc_found;
    logic [LAT_W-1:0]    alloc_cnt;
    logic                long_done_q, long_done_d;
    logic [REG_AW-1:0]   long_regD_q, long_regD_d;

    assign srcA_live = hz.I_dec_useA && (hz.I_dec_regA != '0);
    assign srcB_live = hz.I_dec_useB && (hz.I_dec_regB != '0);
    assign dst_live  = hz.I_dec_we && (hz.I_dec_regD != '0);

    for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_sb
        assign sb_hit[gi] = sb_valid_q[gi] &&
                            ((srcA_live && hz.I_dec_regA == sb_regD_q[gi]) ||
                             (srcB_live && hz.I_dec_regB == sb_regD_q[gi]) ||
                             (dst_live  && hz.I_dec_regD == sb_regD_q[gi]));
        assign sb_ready[gi] = sb_valid_q[gi] && (sb_cnt_q[gi] == LAT_W'(1));
    end

    assign sb_full  = &sb_valid_q;
    assign sb_stall = hz.I_dec_valid && ((|sb_hit) || (hz.I_dec_isLong && sb_full));
    assign lu_stall = hz.I_dec_valid && load_pending_q &&
                      ((srcA_live && hz.I_dec_regA == load_regD_q) ||
                       (srcB_live && hz.I_dec_regB == load_regD_q));
    assign stall     = lu_stall || sb_stall;
    assign issue     = hz.I_dec_valid && !stall && !hz.I_stall_ext && !hz.I_flush;
    assign alloc_req = issue && hz.I_dec_isLong && dst_live;
    assign alloc_cnt = (hz.I_dec_lat == '0) ? LAT_W'(1) : hz.I_dec_lat;

    // Walk from oldest to youngest so the youngest matching stage wins.
    always_comb begin
        selA = '0;
        selB = '0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (hz.I_fwd_we[k] && hz.I_dec_regA != '0 &&
                hz.I_fwd_regD[k*REG_AW +: REG_AW] == hz.I_dec_regA)
                selA = FW'(k + 1);
            if (hz.I_fwd_we[k] && hz.I_dec_regB != '0 &&
                hz.I_fwd_regD[k*REG_AW +: REG_AW] == hz.I_dec_regB)
                selB = FW'(k + 1);
        end
    end

    always_comb begin
        fwdA_d = fwdA_q;
        fwdB_d = fwdB_q;
        if (hz.I_flush) begin
            fwdA_d = '0;
            fwdB_d = '0;
        end else if (issue) begin
            fwdA_d = selA;
            fwdB_d = selB;
        end
        load_pending_d = issue && hz.I_dec_isLoad && hz.I_dec_we;
        load_regD_d    = load_pending_d ? hz.I_dec_regD : load_regD_q;
    end

    // Allocation looks at pre-retire valid bits, so a slot freed this cycle stays unused.
    always_comb begin
        sb_valid_d   = sb_valid_q;
        sb_regD_d    = sb_regD_q;
        sb_cnt_d     = sb_cnt_q;
        long_done_d  = 1'b0;
        long_regD_d  = long_regD_q;
        retire_found = 1'b0;
        alloc_found  = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb_valid_q[i] && sb_cnt_q[i] > LAT_W'(1))
                sb_cnt_d[i] = sb_cnt_q[i] - LAT_W'(1);
        end
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (!retire_found && sb_ready[i]) begin
                retire_found  = 1'b1;
                sb_valid_d[i] = 1'b0;
                long_done_d   = 1'b1;
                long_regD_d   = sb_regD_q[i];
            end
        end
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (alloc_req && !alloc_found && !sb_valid_q[i]) begin
                alloc_found   = 1'b1;
                sb_valid_d[i] = 1'b1;
                sb_regD_d[i]  = hz.I_dec_regD;
                sb_cnt_d[i]   = alloc_cnt;
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            fwdA_q         <= '0;
            fwdB_q         <= '0;
            load_pending_q <= 1'b0;
            load_regD_q    <= '0;
            sb_valid_q     <= '0;
            long_done_q    <= 1'b0;
            long_regD_q    <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_regD_q[i] <= '0;
                sb_cnt_q[i]  <= '0;
            end
        end else begin
            fwdA_q         <= fwdA_d;
            fwdB_q         <= fwdB_d;
            load_pending_q <= load_pending_d;
            load_regD_q    <= load_regD_d;
            sb_valid_q     <= sb_valid_d;
            sb_regD_q      <= sb_regD_d;
            sb_cnt_q       <= sb_cnt_d;
            long_done_q    <= long_done_d;
            long_regD_q    <= long_regD_d;
        end
    end

    assign hz.O_fwdA      = fwdA_q;
    assign hz.O_fwdB      = fwdB_q;
    assign hz.O_stall     = stall;
    assign hz.O_bubble    = stall;
    assign hz.O_sb_full   = sb_full;
    assign hz.O_long_done = long_done_q;
    assign hz.O_long_regD = long_regD_q;

`ifdef CEESPU_HAZARD_STATS_EN
    logic [31:0] stat_stalls_q, stat_stalls_d, stat_long_q, stat_long_d;

    // Both counters stick at all-ones instead of wrapping.
    always_comb begin
        stat_stalls_d = stat_stalls_q;
        stat_long_d   = stat_long_q;
        if (stall && stat_stalls_q != 32'hFFFF_FFFF)
            stat_stalls_d = stat_stalls_q + 32'd1;
        if (alloc_req && stat_long_q != 32'hFFFF_FFFF)
            stat_long_d = stat_long_q + 32'd1;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            stat_stalls_q <= '0;
            stat_long_q   <= '0;
        end else begin
            stat_stalls_q <= stat_stalls_d;
            stat_long_q   <= stat_long_d;
        end
    end

    assign hz.O_stat_stalls = stat_stalls_q;
    assign hz.O_stat_long   = stat_long_q;
`endif
endmodule

// File: tb/tb_ceespu_hazard_unit.sv
// Self-checking bench for ceespu_hazard_unit: forwarding table, load-use, long-op
// scoreboard fill/retire ordering, flush and asynchronous reset sequences.
module tb_ceespu_hazard_unit;
    localparam int REG_AW     = 5;
    localparam int FWD_STAGES = 2;
    localparam int SB_DEPTH   = 4;
    localparam int LAT_W      = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ceespu_hazard_if #(.REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES), .LAT_W(LAT_W)) hz();

    ceespu_hazard_unit #(
        .REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES), .SB_DEPTH(SB_DEPTH), .LAT_W(LAT_W)
    ) dut (
        .I_clk  (clk),
        .I_rst_n(rst_n),
        .hz     (hz)
    );

    typedef struct {
        logic       v, fl, ext, uA, uB, we, ld, lg;
        logic [4:0] rA, rB, rD;
        logic [3:0] lat;
        logic [1:0] fwe;
        logic [9:0] frd;
        logic       xs, xf;
        logic [1:0] xa, xb;
        logic       xd;
        logic [4:0] xr;
    } vec_t;

    typedef struct {
        string      name;
        logic       xs, xf;
        logic [1:0] xa, xb;
        logic       xd;
        logic [4:0] xr;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        hz.I_dec_valid  = v.v;
        hz.I_flush      = v.fl;
        hz.I_stall_ext  = v.ext;
        hz.I_dec_useA   = v.uA;
        hz.I_dec_useB   = v.uB;
        hz.I_dec_we     = v.we;
        hz.I_dec_isLoad = v.ld;
        hz.I_dec_isLong = v.lg;
        hz.I_dec_regA   = v.rA;
        hz.I_dec_regB   = v.rB;
        hz.I_dec_regD   = v.rD;
        hz.I_dec_lat    = v.lat;
        hz.I_fwd_we     = v.fwe;
        hz.I_fwd_regD   = v.frd;
    endtask

    // One decode cycle: combinational outputs checked before the edge, registered ones after.
    task automatic step(input string name, input vec_t v);
        exp_t e;
        @(negedge clk);
        drive(v);
        e.name = name; e.xs = v.xs; e.xf = v.xf;
        e.xa = v.xa; e.xb = v.xb; e.xd = v.xd; e.xr = v.xr;
        exp_q.push_back(e);
        #1;
        chk({name, ".stall"},  32'(hz.O_stall),   32'(exp_q[0].xs));
        chk({name, ".bubble"}, 32'(hz.O_bubble),  32'(exp_q[0].xs));
        chk({name, ".full"},   32'(hz.O_sb_full), 32'(exp_q[0].xf));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({e.name, ".fwdA"},  32'(hz.O_fwdA),      32'(e.xa));
        chk({e.name, ".fwdB"},  32'(hz.O_fwdB),      32'(e.xb));
        chk({e.name, ".done"},  32'(hz.O_long_done), 32'(e.xd));
        chk({e.name, ".ldRegD"}, 32'(hz.O_long_regD), 32'(e.xr));
        $display("[TB] %s stall=%0d full=%0d fwdA=%0d fwdB=%0d done=%0d regD=%0d",
                 e.name, e.xs, e.xf, hz.O_fwdA, hz.O_fwdB, hz.O_long_done, hz.O_long_regD);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, got running, expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t tbl[8];
        vec_t v;
        v = '{default: '0};
        drive(v);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.fwdA",   32'(hz.O_fwdA),      32'd0);
        chk("reset.fwdB",   32'(hz.O_fwdB),      32'd0);
        chk("reset.stall",  32'(hz.O_stall),     32'd0);
        chk("reset.bubble", 32'(hz.O_bubble),    32'd0);
        chk("reset.full",   32'(hz.O_sb_full),   32'd0);
        chk("reset.done",   32'(hz.O_long_done), 32'd0);
        chk("reset.regD",   32'(hz.O_long_regD), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Forwarding selects: stage k result -> k+1, youngest wins, r0 never forwarded.
        tbl[0] = '{default: '0, v: 1'b1, rA: 5'd1, rB: 5'd2, uA: 1'b1, uB: 1'b1, we: 1'b1,
                   rD: 5'd3, fwe: 2'b01, frd: 10'd1, xa: 2'd1};
        tbl[1] = '{default: '0, v: 1'b1, rA: 5'd1, rB: 5'd1, uA: 1'b1, uB: 1'b1,
                   fwe: 2'b11, frd: 10'h21, xa: 2'd1, xb: 2'd1};
        tbl[2] = '{default: '0, v: 1'b1, rA: 5'd0, rB: 5'd2, uA: 1'b1, uB: 1'b1,
                   fwe: 2'b11, frd: 10'd64, xb: 2'd2};
        tbl[3] = '{default: '0, v: 1'b1, rA: 5'd5, rB: 5'd6, uA: 1'b1, uB: 1'b1,
                   fwe: 2'b10, frd: 10'd166, xa: 2'd2};
        tbl[4] = '{default: '0, ext: 1'b1, v: 1'b1, rA: 5'd1, uA: 1'b1,
                   fwe: 2'b01, frd: 10'd1, xa: 2'd2};
        tbl[5] = '{default: '0, rA: 5'd1, uA: 1'b1, fwe: 2'b01, frd: 10'd1, xa: 2'd2};
        tbl[6] = '{default: '0, fl: 1'b1, v: 1'b1, rA: 5'd1, uA: 1'b1, fwe: 2'b01, frd: 10'd1};
        tbl[7] = '{default: '0, v: 1'b1, rA: 5'd7, uA: 1'b1, fwe: 2'b01, frd: 10'd7, xa: 2'd1};
        for (int i = 0; i < 8; i++) step($sformatf("fwd%0d", i), tbl[i]);

        // Load r4 then a reader of r4: exactly one stall cycle.
        v = '{default: '0, v: 1'b1, ld: 1'b1, we: 1'b1, rD: 5'd4, rA: 5'd2, uA: 1'b1};
        step("lu_load", v);
        v = '{default: '0, v: 1'b1, rA: 5'd4, uA: 1'b1, rB: 5'd1, uB: 1'b1, we: 1'b1,
              rD: 5'd8, xs: 1'b1};
        step("lu_stall", v);
        v.xs = 1'b0; v.fwe = 2'b01; v.frd = 10'd4; v.xa = 2'd1;
        step("lu_issue", v);

        // Long op r5 lat 3: WAW stall, then RAW stalls until it retires.
        v = '{default: '0, v: 1'b1, lg: 1'b1, we: 1'b1, rD: 5'd5, lat: 4'd3, rA: 5'd1, uA: 1'b1};
        step("div_issue", v);
        v = '{default: '0, v: 1'b1, we: 1'b1, rD: 5'd5, xs: 1'b1};
        step("div_waw", v);
        v = '{default: '0, v: 1'b1, rA: 5'd5, uA: 1'b1, we: 1'b1, rD: 5'd6, xs: 1'b1};
        step("div_raw1", v);
        v.xd = 1'b1; v.xr = 5'd5;
        step("div_raw2", v);
        v.xs = 1'b0; v.xd = 1'b0;
        step("div_add", v);

        // Fill all four entries with lat 15, then a fifth long op waits for a free slot.
        for (int s = 0; s < 4; s++) begin
            v = '{default: '0, v: 1'b1, lg: 1'b1, we: 1'b1, rD: 5'(10 + s), lat: 4'd15, xr: 5'd5};
            if (s == 3) begin
                v.rA = 5'd1; v.uA = 1'b1; v.fwe = 2'b01; v.frd = 10'd1; v.xa = 2'd1;
            end
            step($sformatf("fill%0d", s), v);
        end
        for (int i = 0; i <= 16; i++) begin
            v = '{default: '0, xr: 5'd5};
            if (i <= 12) begin
                v.v = 1'b1; v.lg = 1'b1; v.we = 1'b1; v.rD = 5'd14; v.lat = 4'd2;
                v.fl = (i == 5);
            end
            v.xs = (i < 12);
            v.xf = (i < 12);
            v.xa = (i < 5) ? 2'd1 : 2'd0;
            v.xd = (i >= 11 && i <= 15);
            case (i)
                11:      v.xr = 5'd10;
                12:      v.xr = 5'd11;
                13:      v.xr = 5'd12;
                14:      v.xr = 5'd14;
                15, 16:  v.xr = 5'd13;
                default: v.xr = 5'd5;
            endcase
            step($sformatf("full%0d", i), v);
        end

        // Asynchronous reset in the middle of a long op and a stalled reader.
        v = '{default: '0, v: 1'b1, lg: 1'b1, we: 1'b1, rD: 5'd7, lat: 4'd5, rA: 5'd1, uA: 1'b1,
              fwe: 2'b01, frd: 10'd1, xa: 2'd1, xr: 5'd13};
        step("rst_long", v);
        @(negedge clk);
        v = '{default: '0, v: 1'b1, rA: 5'd7, uA: 1'b1};
        drive(v);
        #1;
        chk("rst.pre_stall", 32'(hz.O_stall), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.fwdA",   32'(hz.O_fwdA),      32'd0);
        chk("rst.fwdB",   32'(hz.O_fwdB),      32'd0);
        chk("rst.stall",  32'(hz.O_stall),     32'd0);
        chk("rst.bubble", 32'(hz.O_bubble),    32'd0);
        chk("rst.full",   32'(hz.O_sb_full),   32'd0);
        chk("rst.done",   32'(hz.O_long_done), 32'd0);
        chk("rst.regD",   32'(hz.O_long_regD), 32'd0);
        $display("[TB] rst_mid fwdA=%0d stall=%0d regD=%0d", hz.O_fwdA, hz.O_stall, hz.O_long_regD);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
